instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Boot-time program loader upstream of the CPU's instruction memory. Accepts a byte stream
//  (valid/ready), assembles little-endian 32-bit instruction words, and writes them to
//  consecutive word addresses from 0. Holds the CPU stalled (cpu_run=0) until the image is
//  complete. The PC advances by 1 per instruction, so addresses are word indices.
// PARAMETERS
//  ADDR_W  8    width of instruction-memory word address
//  DEPTH   256  max words accepted (must be <= 2**ADDR_W)
// PORTS
//  sysclk      in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  rx_valid    in   1       byte available on rx_data
//  rx_data     in   8       stream byte
//  rx_ready    out  1       loader can accept a byte this cycle
//  reload      in   1       sync pulse: abandon/restart load, stop CPU
//  imem_we     out  1       instruction-memory write strobe (1-cycle pulse)
//  imem_addr   out  ADDR_W  word address of write
//  imem_wdata  out  32      instruction word
//  cpu_run     out  1       1 = CPU may execute (image loaded)
//  load_err    out  1       1 = image rejected; sticky until reload/reset
//  word_count  out  16      words written so far
// BEHAVIOUR
//  - Reset: state IDLE; rx_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; cpu_run=0;
//    load_err=0; word_count=0; byte index=0.
//  - Byte accepted only when rx_valid & rx_ready in the same cycle.
//  - Image format: N_lo, N_hi (16-bit word count N), then 4*N payload bytes, LSB first.
//  - States: IDLE (take N_lo) -> HDR (take N_hi) -> LOAD | DONE | ERR.
//    N==0 -> DONE, no writes. N>DEPTH -> ERR. Else LOAD.
//  - LOAD: bytes shift into word at lane = byte index (0..3). Cycle after accepting lane 3:
//    imem_we=1 for exactly one cycle, imem_addr=word_count[ADDR_W-1:0], imem_wdata=word;
//    word_count increments on the same edge the strobe drops. Back-to-back bytes accepted
//    every cycle; no stall on writes (rx_ready stays 1 in LOAD).
//  - Last word written -> DONE (or CSUM when CHECKSUM_EN). Transition occurs on the same edge
//    that raises imem_we; cpu_run rises the cycle after the final imem_we pulse, never with it.
//  - DONE: rx_ready=0, cpu_run=1, extra bytes not accepted. ERR: rx_ready=0, cpu_run=0,
//    load_err=1.
//  - reload (any state): next state IDLE; byte index, word_count, load_err, cpu_run cleared;
//    a pending partial word is discarded (no imem_we). reload with concurrent byte handshake:
//    reload wins, byte dropped. A pending imem_we pulse from the previous cycle still completes.
//  - rst_n asserted mid-load: all outputs to reset values immediately (async); memory
//    contents undefined to CPU until next complete load.
// CONFIGURATION
//  INSTR_LOADER_CHECKSUM_EN defined: after payload, state CSUM takes one byte = XOR of all
//    4*N payload bytes; match -> DONE, mismatch -> ERR (written words remain, cpu_run=0).
//    N==0 expects checksum byte 0x00.
//  Not defined: no CSUM state; DONE directly after last word; running XOR logic absent.
// STRUCTURE
//  Package instr_loader_pkg: state enum (IDLE, HDR, LOAD, CSUM, DONE, ERR), HDR_BYTES=2,
//    BYTES_PER_WORD=4.
//  Sub-module word_assembler: byte lane index counter + 32-bit shift/lane register, emits
//    word_valid pulse on lane 3; FSM, address counter, checksum stay in instr_loader.
// TESTING
//  1. Stream 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093;
//     cpu_run=1 one cycle after second imem_we; word_count=2.
//  2. Header 00 00 -> no imem_we, DONE, cpu_run=1 two cycles after N_hi accepted.
//  3. Header 01 01 (N=257, DEPTH=256) -> load_err=1, rx_ready=0, cpu_run=0, no writes.
//  4. N=3, reload pulsed after 6 payload bytes -> one write at addr0 only, state IDLE,
//     word_count=0; new image N=1 then writes addr0.
//  5. rx_valid toggled randomly during N=4 load -> identical writes to gap-free stream;
//     rst_n low mid-word -> all outputs reset asynchronously, no spurious imem_we.
//  6. CHECKSUM_EN: N=1, bytes 11 22 33 44, checksum 0x44 -> DONE; checksum 0x45 -> ERR,
//     load_err=1, cpu_run=0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

    typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, DONE, ERR} state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Collects stream bytes LSB-first into a 32-bit word; word_valid marks the lane-3 byte.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          byte_en,
    input  logic [7:0]                    byte_in,
    output logic                          word_valid,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]                 lane;
    logic [8*(BYTES_PER_WORD-1)-1:0]   lo_bytes;

    assign word_valid = byte_en && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, lo_bytes};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lane <= '0;
        else if (clr)
            lane <= '0;
        else if (byte_en)
            lane <= lane + 1'b1;
    end

    // Shift right so that after three bytes the oldest sits in the low lane.
    always_ff @(posedge clk) begin
        if (byte_en)
            lo_bytes <= {byte_in, lo_bytes[8*(BYTES_PER_WORD-1)-1:8]};
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: header N (LE 16-bit) then 4*N payload bytes written as words from address 0.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic [15:0]       word_count
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t                   state, state_nxt;
    logic [7:0]               n_lo;
    logic [8*HDR_BYTES-1:0]   n_words;
    logic [8*HDR_BYTES-1:0]   hdr_n;
    logic                     acc, byte_en, word_valid;
    logic [31:0]              word;

    assign rx_ready = (state == IDLE) || (state == HDR) || (state == LOAD) || (state == CSUM);
    assign acc      = rx_valid && rx_ready && !reload;
    assign byte_en  = acc && (state == LOAD);
    assign hdr_n    = {rx_data, n_lo};
    assign load_err = (state == ERR);

    word_assembler u_asm (
        .clk        (sysclk),
        .rst_n      (rst_n),
        .clr        (reload),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge sysclk) begin
        if (state == IDLE)
            csum <= '0;
        else if (byte_en)
            csum <= csum ^ rx_data;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acc) state_nxt = HDR;
            HDR: begin
                if (acc) begin
                    if (hdr_n == '0)
                        state_nxt = PAYLOAD_END;
                    else if (int'(hdr_n) > DEPTH)
                        state_nxt = ERR;
                    else
                        state_nxt = LOAD;
                end
            end
            // The final word's lane-3 byte ends the payload; the write strobe follows next cycle.
            LOAD: if (word_valid && (word_count + 16'd1 == n_words)) state_nxt = PAYLOAD_END;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM: if (acc) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
            default: ;
        endcase
        if (reload)
            state_nxt = IDLE;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            cpu_run    <= 1'b0;
        end else begin
            state   <= state_nxt;
            imem_we <= word_valid;
            if (word_valid) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word;
            end
            if (reload)
                word_count <= '0;
            else if (imem_we)
                word_count <= word_count + 16'd1;
            // Registered from state so cpu_run never coincides with the last write strobe.
            cpu_run <= !reload && (state == DONE);
        end
    end

    always_ff @(posedge sysclk) begin
        if (acc && (state == IDLE))
            n_lo <= rx_data;
        if (acc && (state == HDR))
            n_words <= hdr_n;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed images plus randomized payloads and gaps.
module tb_instr_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              sysclk;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              load_err;
    logic [15:0]       word_count;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t wq[$];
    time rise_t      = 0;
    logic prev_run   = 1'b0;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write collector and cpu_run edge detector, sampled mid-cycle.
    always @(negedge sysclk) begin
        if (imem_we)
            wq.push_back('{imem_addr, imem_wdata});
        if (cpu_run && !prev_run)
            rise_t = $time;
        prev_run = cpu_run;
        if (imem_we || cpu_run)
            chk("we_run_overlap", {63'd0, imem_we & cpu_run}, 64'd0);
    end

    task automatic send_byte(input byte unsigned b, input int gap_max, output time t);
        if (gap_max > 0)
            repeat ($urandom_range(0, gap_max)) @(negedge sysclk);
        rx_valid = 1'b1;
        rx_data  = b;
        t        = $time;
        @(negedge sysclk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge sysclk);
        reload = 1'b0;
    endtask

    // Reference: word i = payload bytes 4i..4i+3 little-endian at address i; N>DEPTH rejected.
    task automatic run_image(input string tag, input int n, input byte unsigned pl[$],
                             input int gap_max, input bit bad);
        byte unsigned x;
        time          t_last;
        bit           hdr_err, exp_done;
        int           exp_words;
        logic [15:0]  nn;
        x       = 8'h00;
        nn      = 16'(n);
        hdr_err = (n > DEPTH);
        pulse_reload();
        wq.delete();
        rise_t = 0;
        send_byte(nn[7:0], gap_max, t_last);
        send_byte(nn[15:8], gap_max, t_last);
        if (!hdr_err)
            foreach (pl[i]) begin
                send_byte(pl[i], gap_max, t_last);
                x = x ^ pl[i];
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (!hdr_err)
            send_byte(bad ? (x ^ 8'h01) : x, gap_max, t_last);
`endif
        exp_done  = !hdr_err && !bad;
        exp_words = hdr_err ? 0 : n;
        repeat (4) @(negedge sysclk);
        chk({tag, ".cpu_run"},    {63'd0, cpu_run},  {63'd0, exp_done});
        chk({tag, ".load_err"},   {63'd0, load_err}, {63'd0, !exp_done});
        chk({tag, ".rx_ready"},   {63'd0, rx_ready}, 64'd0);
        chk({tag, ".word_count"}, 64'(word_count),   64'(exp_words));
        chk({tag, ".nwrites"},    64'(wq.size()),    64'(exp_words));
        for (int i = 0; i < exp_words && i < wq.size(); i++) begin
            chk({tag, ".addr"}, 64'(wq[i].a), 64'(i % (1 << ADDR_W)));
            chk({tag, ".data"}, 64'(wq[i].d),
                64'({pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]}));
        end
        if (exp_done)
            chk({tag, ".run_time"}, 64'(rise_t), 64'(t_last + 20));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned pl[$];
        time          t;
        int           n;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        #3;
        chk("rst.rx_ready",   {63'd0, rx_ready}, 64'd1);
        chk("rst.imem_we",    {63'd0, imem_we},  64'd0);
        chk("rst.imem_addr",  64'(imem_addr),    64'd0);
        chk("rst.imem_wdata", 64'(imem_wdata),   64'd0);
        chk("rst.cpu_run",    {63'd0, cpu_run},  64'd0);
        chk("rst.load_err",   {63'd0, load_err}, 64'd0);
        chk("rst.word_count", 64'(word_count),   64'd0);
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);

        // Two-word image with known instructions
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_image("t1", 2, pl, 0, 1'b0);
        chk("t1.w0", 64'(wq.size() > 0 ? wq[0].d : 32'hDEADBEEF), 64'h00000013);
        chk("t1.w1", 64'(wq.size() > 1 ? wq[1].d : 32'hDEADBEEF), 64'h00100093);

        // Extra bytes after DONE are refused
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        repeat (3) @(negedge sysclk);
        chk("t1.extra_ready", {63'd0, rx_ready}, 64'd0);
        rx_valid = 1'b0;
        @(negedge sysclk);
        chk("t1.extra_nwr", 64'(wq.size()),    64'd2);
        chk("t1.extra_wc",  64'(word_count),   64'd2);
        chk("t1.extra_run", {63'd0, cpu_run},  64'd1);

        // Empty image and oversized header
        pl.delete();
        run_image("t2", 0, pl, 0, 1'b0);
        run_image("t3", 257, pl, 0, 1'b0);

        // Reload after six payload bytes of a three-word image
        pulse_reload();
        wq.delete();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        send_byte(8'h03, 0, t);
        send_byte(8'h00, 0, t);
        for (int i = 0; i < 6; i++) send_byte(pl[i], 0, t);
        pulse_reload();
        repeat (2) @(negedge sysclk);
        chk("t4.nwrites",  64'(wq.size()),     64'd1);
        chk("t4.addr",     64'(wq.size() > 0 ? wq[0].a : 8'hFF), 64'd0);
        chk("t4.data",     64'(wq.size() > 0 ? wq[0].d : 32'd0),
            64'({pl[3], pl[2], pl[1], pl[0]}));
        chk("t4.wc",       64'(word_count),    64'd0);
        chk("t4.rx_ready", {63'd0, rx_ready},  64'd1);
        chk("t4.cpu_run",  {63'd0, cpu_run},   64'd0);
        // Byte coinciding with reload must be dropped
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(negedge sysclk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        run_image("t4b", 1, pl, 0, 1'b0);

        // Reload in the cycle the write strobe is pending
        wq.delete();
        pulse_reload();
        wq.delete();
        send_byte(8'h02, 0, t);
        send_byte(8'h00, 0, t);
        for (int i = 0; i < 4; i++) send_byte(pl[i], 0, t);
        pulse_reload();
        @(negedge sysclk);
        chk("t4c.nwrites", 64'(wq.size()),   64'd1);
        chk("t4c.wc",      64'(word_count),  64'd0);

        // Same payload with and without gaps
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
        run_image("t5gap", 4, pl, 3, 1'b0);
        run_image("t5nogap", 4, pl, 0, 1'b0);

        // Asynchronous reset mid-word
        pulse_reload();
        wq.delete();
        send_byte(8'h04, 0, t);
        send_byte(8'h00, 0, t);
        for (int i = 0; i < 6; i++) send_byte(pl[i], 1, t);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5r.rx_ready",   {63'd0, rx_ready}, 64'd1);
        chk("t5r.imem_we",    {63'd0, imem_we},  64'd0);
        chk("t5r.imem_addr",  64'(imem_addr),    64'd0);
        chk("t5r.imem_wdata", 64'(imem_wdata),   64'd0);
        chk("t5r.cpu_run",    {63'd0, cpu_run},  64'd0);
        chk("t5r.load_err",   {63'd0, load_err}, 64'd0);
        chk("t5r.word_count", 64'(word_count),   64'd0);
        wq.delete();
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("t5r.nwrites", 64'(wq.size()), 64'd0);
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        run_image("t5c", 1, pl, 0, 1'b0);

        // Full-depth image exercises the top address
        pl.delete();
        for (int i = 0; i < 4 * DEPTH; i++) pl.push_back(8'($urandom));
        run_image("depth", DEPTH, pl, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            pl.delete();
            for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
            run_image("rnd", n, pl, $urandom_range(0, 2), 1'b0);
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_image("t6ok", 1, pl, 0, 1'b0);
        run_image("t6bad", 1, pl, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
